// File: rtl/load_store_unit.sv
// Data-memory access stage: turns ALUResult/WriteData into a valid/ready memory
// request, aligns and extends load data, and stalls the core until the access ends.
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] LoadData,
    output logic        Stall,
    output logic        Fault,
    output logic        BusError,
    output logic        DReqValid,
    input  logic        DReqReady,
    output logic        DReqWe,
    output logic [31:0] DReqAddr,
    output logic [3:0]  DReqBe,
    output logic [31:0] DReqWData,
    input  logic        DRspValid,
    input  logic [31:0] DRspRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] ldata_q;
    logic [7:0]  cnt_q;
    logic        bus_err_q;

    logic        access;
    logic        illegal;
    logic        timeout;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] ldata_d;

    // Access legality: width/alignment and encoding checks for the current request
    always_comb begin
        access  = MemRead | MemWrite;
        illegal = 1'b0;
        if (MemRead && MemWrite) begin
            illegal = 1'b1;
        end else if (MemRead) begin
            case (Funct3)
                3'b000, 3'b100: illegal = 1'b0;
                3'b001, 3'b101: illegal = ALUResult[0];
                3'b010:         illegal = |ALUResult[1:0];
                default:        illegal = 1'b1;
            endcase
        end else if (MemWrite) begin
            case (Funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = ALUResult[0];
                3'b010:  illegal = |ALUResult[1:0];
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = '0;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << ALUResult[1:0];
                    wdata_c = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << {ALUResult[1], 1'b0};
                    wdata_c = {2{WriteData[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = WriteData;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    rsp_byte = DRspRData[7:0];
            2'd1:    rsp_byte = DRspRData[15:8];
            2'd2:    rsp_byte = DRspRData[23:16];
            default: rsp_byte = DRspRData[31:24];
        endcase
        rsp_half = off_q[1] ? DRspRData[31:16] : DRspRData[15:0];
        case (f3_q)
            3'b000:  ldata_d = {{24{rsp_byte[7]}}, rsp_byte};
            3'b100:  ldata_d = {24'd0, rsp_byte};
            3'b001:  ldata_d = {{16{rsp_half[15]}}, rsp_half};
            3'b101:  ldata_d = {16'd0, rsp_half};
            default: ldata_d = DRspRData;
        endcase
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            ldata_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus_err_q <= 1'b0;
                    if (access && !illegal) begin
                        addr_q  <= ALUResult[31:2];
                        off_q   <= ALUResult[1:0];
                        f3_q    <= Funct3;
                        we_q    <= MemWrite;
                        be_q    <= be_c;
                        wdata_q <= wdata_c;
                        ldata_q <= '0;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A handshake on the final budget cycle still completes normally
                    if (DReqReady) begin
                        state_q <= we_q ? DONE : WAIT;
                    end else if (timeout) begin
                        state_q   <= DONE;
                        bus_err_q <= 1'b1;
                        ldata_q   <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (DRspValid) begin
                        ldata_q <= ldata_d;
                        state_q <= DONE;
                    end else if (timeout) begin
                        state_q   <= DONE;
                        bus_err_q <= 1'b1;
                        ldata_q   <= '0;
                    end
                end
                DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Stall = !reset && (((state_q == IDLE) && access && !illegal) ||
                              (state_q == REQ) || (state_q == WAIT));
    assign Fault     = !reset && (state_q == IDLE) && illegal;
    assign BusError  = bus_err_q;
    assign LoadData  = (state_q == DONE) ? ldata_q : '0;
    assign DReqValid = (state_q == REQ);
    assign DReqWe    = we_q;
    assign DReqAddr  = {addr_q, 2'b00};
    assign DReqBe    = be_q;
    assign DReqWData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of single accesses plus
// hand-written backpressure, timeout and reset-mid-access sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] LoadData;
    logic        Stall, Fault, BusError;
    logic        DReqValid, DReqReady, DReqWe;
    logic [31:0] DReqAddr, DReqWData;
    logic [3:0]  DReqBe;
    logic        DRspValid;
    logic [31:0] DRspRData;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .LoadData(LoadData), .Stall(Stall), .Fault(Fault), .BusError(BusError),
        .DReqValid(DReqValid), .DReqReady(DReqReady), .DReqWe(DReqWe),
        .DReqAddr(DReqAddr), .DReqBe(DReqBe), .DReqWData(DReqWData),
        .DRspValid(DRspValid), .DRspRData(DRspRData)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_inputs;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        ALUResult = '0;
        WriteData = '0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = v.addr & 32'hFFFF_FFFC;
        DReqReady = 1'b1;
        tick();
        drive(v.rd, v.wr, v.f3, v.addr, v.wd);
        #1;
        chk({v.name, " fault"}, {31'd0, Fault}, {31'd0, v.fault});
        chk({v.name, " stall_idle"}, {31'd0, Stall}, {31'd0, !v.fault});
        if (v.fault) begin
            chk({v.name, " no_req"}, {31'd0, DReqValid}, 32'd0);
            drop_inputs();
            tick();
            chk({v.name, " no_req_after"}, {31'd0, DReqValid}, 32'd0);
            chk({v.name, " fault_clear"}, {31'd0, Fault}, 32'd0);
        end else begin
            tick();
            chk({v.name, " req_valid"}, {31'd0, DReqValid}, 32'd1);
            chk({v.name, " req_stall"}, {31'd0, Stall}, 32'd1);
            chk({v.name, " req_addr"}, DReqAddr, exp_addr);
            chk({v.name, " req_be"}, {28'd0, DReqBe}, {28'd0, v.be});
            chk({v.name, " req_we"}, {31'd0, DReqWe}, {31'd0, v.wr});
            if (v.wr) chk({v.name, " req_wdata"}, DReqWData, v.wdat);
            tick();
            if (v.rd) begin
                chk({v.name, " wait_valid"}, {31'd0, DReqValid}, 32'd0);
                chk({v.name, " wait_stall"}, {31'd0, Stall}, 32'd1);
                DRspValid = 1'b1;
                DRspRData = v.rdata;
                tick();
                DRspValid = 1'b0;
                DRspRData = '0;
            end
            chk({v.name, " done_stall"}, {31'd0, Stall}, 32'd0);
            chk({v.name, " done_load"}, LoadData, v.load);
            chk({v.name, " done_buserr"}, {31'd0, BusError}, 32'd0);
            drop_inputs();
            tick();
            chk({v.name, " idle_load"}, LoadData, 32'd0);
            chk({v.name, " idle_stall"}, {31'd0, Stall}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //          name      rd    wr    f3      addr           wd             rdata          flt   be       wdata          load
        vecs[0]  = '{"SW",     1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{"SB",     1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[2]  = '{"SH",     1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[3]  = '{"LB",     1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80};
        vecs[4]  = '{"LBU",    1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'h0000_0080};
        vecs[5]  = '{"LH",     1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'h0000_0080};
        vecs[6]  = '{"LHU0",   1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'h0000_FF00};
        vecs[7]  = '{"LH0",    1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF00};
        vecs[8]  = '{"LW",     1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,         32'h1234_5678, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
        vecs[9]  = '{"LB1",    1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0080_FF00, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FFFF};
        vecs[10] = '{"LWmis",  1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{"RDWR",   1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[12] = '{"LD011",  1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[13] = '{"ST100",  1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[14] = '{"SHmis",  1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[15] = '{"SWmis",  1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};

        reset = 1'b1;
        drop_inputs();
        DReqReady = 1'b0;
        DRspValid = 1'b0;
        DRspRData = '0;
        tick();
        tick();
        chk("rst valid", {31'd0, DReqValid}, 32'd0);
        chk("rst stall", {31'd0, Stall}, 32'd0);
        chk("rst fault", {31'd0, Fault}, 32'd0);
        chk("rst buserr", {31'd0, BusError}, 32'd0);
        chk("rst load", LoadData, 32'd0);
        chk("rst addr", DReqAddr, 32'd0);
        chk("rst be", {28'd0, DReqBe}, 32'd0);
        reset = 1'b0;

        // Response while idle must be ignored
        DRspValid = 1'b1;
        DRspRData = 32'hFFFF_FFFF;
        tick();
        chk("idle rsp load", LoadData, 32'd0);
        chk("idle rsp stall", {31'd0, Stall}, 32'd0);
        DRspValid = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Backpressure: ready low for 3 REQ cycles, response 2 cycles after handshake
        DReqReady = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp valid", {31'd0, DReqValid}, 32'd1);
            chk("bp addr", DReqAddr, 32'h0000_0300);
            chk("bp be", {28'd0, DReqBe}, 32'hF);
            chk("bp we", {31'd0, DReqWe}, 32'd0);
            chk("bp stall", {31'd0, Stall}, 32'd1);
            tick();
        end
        chk("bp valid4", {31'd0, DReqValid}, 32'd1);
        DReqReady = 1'b1;
        tick();
        DReqReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp wait valid", {31'd0, DReqValid}, 32'd0);
            chk("bp wait stall", {31'd0, Stall}, 32'd1);
            tick();
        end
        DRspValid = 1'b1;
        DRspRData = 32'hCAFE_F00D;
        tick();
        DRspValid = 1'b0;
        chk("bp done load", LoadData, 32'hCAFE_F00D);
        chk("bp done stall", {31'd0, Stall}, 32'd0);
        chk("bp done buserr", {31'd0, BusError}, 32'd0);
        drop_inputs();
        tick();

        // Timeout: no handshake, DONE with BusError 8 cycles after REQ entry
        DReqReady = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to valid", {31'd0, DReqValid}, 32'd1);
            chk("to buserr", {31'd0, BusError}, 32'd0);
        end
        tick();
        chk("to buserr pulse", {31'd0, BusError}, 32'd1);
        chk("to done valid", {31'd0, DReqValid}, 32'd0);
        chk("to done load", LoadData, 32'd0);
        chk("to done stall", {31'd0, Stall}, 32'd0);
        drop_inputs();
        tick();
        chk("to buserr clear", {31'd0, BusError}, 32'd0);

        // Reset asserted while waiting for a load response
        DReqReady = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        tick();
        tick();
        chk("rw wait stall", {31'd0, Stall}, 32'd1);
        drop_inputs();
        DReqReady = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw valid", {31'd0, DReqValid}, 32'd0);
        chk("rw stall", {31'd0, Stall}, 32'd0);
        chk("rw load", LoadData, 32'd0);
        DRspValid = 1'b1;
        DRspRData = 32'h1111_2222;
        tick();
        DRspValid = 1'b0;
        chk("rw late rsp load", LoadData, 32'd0);
        chk("rw late rsp stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("rw late rsp load2", LoadData, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the ALU in the single-cycle core. It takes ALUResult as the effective address, issues a valid/ready request to data memory, and aligns and sign- or zero-extends load data for write-back. It holds the core with Stall until the access finishes, and flags misaligned or illegal accesses and memory timeouts.

Parameters:
MEM_TIMEOUT, 64, max cycles spent in REQ+WAIT before the access is aborted with BusError (range 2..255)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high
MemRead  input  1  current instruction is a load
MemWrite  input  1  current instruction is a store
Funct3  input  3  RISC-V funct3 of load/store
ALUResult  input  32  effective byte address from ALU
WriteData  input  32  store data (rs2)
LoadData  output  32  aligned/extended load result, valid while Stall=0 in DONE
Stall  output  1  hold PC/regfile write while high
Fault  output  1  misaligned/illegal access, 1-cycle, no memory request
BusError  output  1  timeout abort, 1-cycle pulse in DONE
DReqValid  output  1  memory request valid
DReqReady  input  1  memory accepts request
DReqWe  output  1  1=write
DReqAddr  output  32  word address {addr[31:2],2'b00}
DReqBe  output  4  byte enables
DReqWData  output  32  lane-replicated store data
DRspValid  input  1  read response valid (loads only)
DRspRData  input  32  read response word

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; captured regs 0.
- FSM IDLE, REQ, WAIT, DONE.
- IDLE, no access (MemRead=MemWrite=0): Stall=0, LoadData=0.
- IDLE, legal access: capture addr/WriteData/Funct3/we into registers; Stall=1 combinationally in the same cycle; next REQ.
- IDLE, illegal access: Fault=1 and Stall=0 in the same cycle; no request issued; stay IDLE. Illegal means any of:
  - MemRead=MemWrite=1
  - load Funct3 in {011,110,111}
  - store Funct3 not in {000,001,010}
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
- REQ: DReqValid=1. Addr/We/Be/WData come from registers and hold stable until the handshake.
  - On DReqValid&DReqReady: store goes to DONE; load goes to WAIT.
- WAIT: DReqValid=0. On DRspValid, register the extracted load data and go to DONE.
  - DRspValid in IDLE/REQ/DONE is ignored.
- DONE: Stall=0 for exactly one cycle, LoadData driven from its register; next state IDLE.
  - The core advances at the end of DONE, so the same instruction is never re-issued.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches MEM_TIMEOUT:
  - drop DReqValid;
  - go to DONE with BusError=1 and LoadData=0.
- Store encoding:
  - SB: Be=4'b0001<<addr[1:0], WData={4{wd[7:0]}}.
  - SH: Be=4'b0011<<{addr[1],1'b0}, WData={2{wd[15:0]}}.
  - SW: Be=4'b1111, WData=wd.
- Load: Be=4'b1111. Select byte addr[1:0] or half addr[1]:
  - LB/LH sign-extend;
  - LBU/LHU zero-extend;
  - LW passes the word.
- Reset mid-access: return to IDLE next edge, DReqValid=0 immediately after. Late DRspValid is ignored.
- Back-to-back accesses: each costs at least 3 cycles (IDLE→REQ→DONE for stores, +WAIT for loads). A new access is sampled only in IDLE.

Test Plan:
- SW addr 0x100, wd 0xDEADBEEF, DReqReady=1: Stall high in IDLE and REQ; DReqAddr 0x100, Be 1111, WData 0xDEADBEEF; DONE one cycle later, Stall=0.
- SB addr 0x103, wd 0x000000A5: Be 1000, WData 0xA5A5A5A5, DReqAddr 0x100.
- LB/LBU addr 0x102, RData 0x0080FF00:
  - LB → LoadData 0xFFFFFF80;
  - LBU → 0x00000080;
  - LH addr 0x102 → 0x00000080.
- LW addr 0x101 → Fault=1 same cycle, Stall=0, DReqValid never asserted.
- MemRead=MemWrite=1 → Fault=1.
- LW with DReqReady held 0 for 3 cycles, then DRspValid after 2 more: DReqValid and fields stable throughout, LoadData correct in DONE.
- LW with MEM_TIMEOUT=8 and no response → BusError pulse 8 cycles after REQ entry, LoadData 0.
- reset asserted in WAIT → IDLE, outputs 0; a following DRspValid does not change LoadData.
